acorn_stream_engine: RTL and testbench

- Sequential, parametrised ACORN-128 state-update engine; processes W state steps per accepted word.
- Holds the 293-bit state and applies the six LFSR pre-updates, keystream bit (ks) and feedback bit (f) each step.
- Streams words in and keystream/cipher words out over valid/ready handshakes.
- Top-level phase sequencing (key/IV load, AD, padding, finalisation, tag) lives upstream. This block only executes the steps it is given.

---
 rtl/acorn_stream_engine.sv | 156 +++++++++++++++
 tb/tb_acorn_stream_engine.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/acorn_stream_engine.sv
// ACORN-128 state-update engine. Runs W sequential state steps per accepted word,
// unrolled combinationally into a single cycle, and registers the per-step result
// bits as one output word. Phase sequencing (key/IV load, AD, padding,
// finalisation, tag) is done upstream; this block only executes the steps it is
// given.
//
// Optional feature: define ACORN_STATE_LOAD_EN to add a direct state load port.
//
// Ports:
//   clk_i         rising-edge clock
//   rst_ni        asynchronous active-low reset
//   clr_i         synchronous clear of state, step counter and output register
//   in_valid_i    input word valid
//   in_ready_o    engine accepts a word this cycle
//   in_data_i     W message/cipher bits, bit 0 is the earliest step
//   in_ca_i       ca control bit applied to every step of the word
//   in_cb_i       cb control bit applied to every step of the word
//   in_mode_i     00 absorb, 01 encrypt, 10 decrypt, 11 absorb
//   out_valid_o   output word valid
//   out_ready_i   downstream accepts the output word
//   out_data_o    W per-step result bits, bit 0 is the earliest step
//   state_out_o   current state s[292:0]
//   step_cnt_o    steps executed since reset/clear, wraps modulo 2^CNT_W
//   state_ld_i    (ACORN_STATE_LOAD_EN) load state_in_i at the next edge
//   state_in_i    (ACORN_STATE_LOAD_EN) state value to load
module acorn_stream_engine #(
  parameter int unsigned W     = 8,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [W-1:0]     in_data_i,
  input  logic             in_ca_i,
  input  logic             in_cb_i,
  input  logic [1:0]       in_mode_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [W-1:0]     out_data_o,
  output logic [292:0]     state_out_o,
`ifdef ACORN_STATE_LOAD_EN
  input  logic             state_ld_i,
  input  logic [292:0]     state_in_i,
`endif
  output logic [CNT_W-1:0] step_cnt_o
);

  if (!(W == 1 || W == 8 || W == 16 || W == 32)) begin : gen_bad_w
    $error("acorn_stream_engine: W must be 1, 8, 16 or 32");
  end

  logic [292:0]     state_q, state_d, state_step;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [W-1:0]     out_data_q, out_data_d, step_res;
  logic             out_valid_q, out_valid_d;
  logic             xfer;

`ifdef ACORN_STATE_LOAD_EN
  assign in_ready_o = (~out_valid_q | out_ready_i) & ~state_ld_i;
`else
  assign in_ready_o = ~out_valid_q | out_ready_i;
`endif
  assign xfer = in_valid_i & in_ready_o;

  // W steps unrolled; each step sees the state left by the previous one.
  always_comb begin : step_unroll
    logic [292:0] s;
    logic         ks, f, m;
    s        = state_q;
    step_res = '0;
    ks       = 1'b0;
    f        = 1'b0;
    m        = 1'b0;
    for (int i = 0; i < W; i++) begin
      // LFSR pre-updates, order matters: each uses the not-yet-updated tap below it
      s[289] = s[289] ^ s[235] ^ s[230];
      s[230] = s[230] ^ s[196] ^ s[193];
      s[193] = s[193] ^ s[160] ^ s[154];
      s[154] = s[154] ^ s[111] ^ s[107];
      s[107] = s[107] ^ s[66] ^ s[61];
      s[61]  = s[61] ^ s[23] ^ s[0];
      ks = s[12] ^ s[154]
         ^ ((s[235] & s[61]) ^ (s[235] & s[193]) ^ (s[61] & s[193]))
         ^ ((s[230] & s[111]) ^ (~s[230] & s[66]));
      f  = s[0] ^ ~s[107]
         ^ ((s[244] & s[23]) ^ (s[244] & s[160]) ^ (s[23] & s[160]))
         ^ (in_ca_i & s[196]) ^ (in_cb_i & ks);
      unique case (in_mode_i)
        2'b01: begin
          m           = in_data_i[i];
          step_res[i] = in_data_i[i] ^ ks;
        end
        2'b10: begin
          m           = in_data_i[i] ^ ks;
          step_res[i] = in_data_i[i] ^ ks;
        end
        default: begin
          m           = in_data_i[i];
          step_res[i] = ks;
        end
      endcase
      s = {f ^ m, s[292:1]};
    end
    state_step = s;
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    if (clr_i) begin
      // Clear wins; a word offered in the same cycle is dropped.
      state_d     = '0;
      cnt_d       = '0;
      out_data_d  = '0;
      out_valid_d = 1'b0;
    end
`ifdef ACORN_STATE_LOAD_EN
    else if (state_ld_i) begin
      state_d     = state_in_i;
      out_valid_d = 1'b0;
    end
`endif
    else if (xfer) begin
      state_d     = state_step;
      cnt_d       = cnt_q + CNT_W'(W);
      out_data_d  = step_res;
      out_valid_d = 1'b1;
    end else if (out_ready_i) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= '0;
      cnt_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign state_out_o = state_q;
  assign step_cnt_o  = cnt_q;
  assign out_data_o  = out_data_q;
  assign out_valid_o = out_valid_q;

endmodule

// File: tb/tb_acorn_stream_engine.sv
// Self-checking bench for acorn_stream_engine (W=8): directed table of single words
// from a cleared state, model-checked encrypt/decrypt round trip, backpressure,
// clear/reset priority, counter wrap and (optionally) the state load port.
module tb_acorn_stream_engine;

  localparam int unsigned W      = 8;
  localparam int unsigned CNT_W  = 16;
  localparam int unsigned NWORDS = 40;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             clr = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [W-1:0]     in_data = '0;
  logic             in_ca = 1'b0;
  logic             in_cb = 1'b0;
  logic [1:0]       in_mode = 2'b00;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [W-1:0]     out_data;
  logic [292:0]     state_out;
  logic [CNT_W-1:0] step_cnt;
`ifdef ACORN_STATE_LOAD_EN
  logic             state_ld = 1'b0;
  logic [292:0]     state_in = '0;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  acorn_stream_engine #(.W(W), .CNT_W(CNT_W)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .clr_i       (clr),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_data_i   (in_data),
    .in_ca_i     (in_ca),
    .in_cb_i     (in_cb),
    .in_mode_i   (in_mode),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_data_o  (out_data),
    .state_out_o (state_out),
`ifdef ACORN_STATE_LOAD_EN
    .state_ld_i  (state_ld),
    .state_in_i  (state_in),
`endif
    .step_cnt_o  (step_cnt)
  );

  typedef struct {
    logic [1:0] mode;
    logic       ca;
    logic       cb;
    logic [7:0] d;
    logic [7:0] exp_out;
    logic [7:0] exp_top;
  } vec_t;

  vec_t vecs [8];

  logic [7:0]   din  [NWORDS];
  logic [7:0]   dexp [NWORDS];
  logic         wca  [NWORDS];
  logic         wcb  [NWORDS];
  logic [292:0] ms, ms_enc;
  logic [7:0]   mo;

  task automatic chk(input string name, input logic [292:0] act, input logic [292:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Bit-serial reference: 8 steps, bit 0 first.
  function automatic logic [292:0] word_step(input logic [292:0] s_in, input logic [7:0] d,
                                             input logic ca, input logic cb,
                                             input logic [1:0] mode, output logic [7:0] o);
    logic [292:0] s;
    logic ks, f, m;
    s = s_in;
    o = '0;
    for (int i = 0; i < 8; i++) begin
      s[289] ^= s[235] ^ s[230];
      s[230] ^= s[196] ^ s[193];
      s[193] ^= s[160] ^ s[154];
      s[154] ^= s[111] ^ s[107];
      s[107] ^= s[66] ^ s[61];
      s[61]  ^= s[23] ^ s[0];
      ks = s[12] ^ s[154] ^ ((s[235] & s[61]) | (s[235] & s[193]) | (s[61] & s[193]))
         ^ (s[230] ? s[111] : s[66]);
      f = s[0] ^ ~s[107] ^ ((s[244] & s[23]) | (s[244] & s[160]) | (s[23] & s[160]))
        ^ (ca & s[196]) ^ (cb & ks);
      m    = (mode == 2'b10) ? (d[i] ^ ks) : d[i];
      o[i] = (mode == 2'b01 || mode == 2'b10) ? (d[i] ^ ks) : ks;
      s = {f ^ m, s[292:1]};
    end
    return s;
  endfunction

  task automatic do_clr();
    @(negedge clk);
    in_valid = 1'b0;
    clr      = 1'b1;
    @(negedge clk);
    clr = 1'b0;
  endtask

  task automatic stream_words(input logic [1:0] mode, input int n);
    for (int k = 0; k <= n; k++) begin
      @(negedge clk);
      if (k > 0) chk($sformatf("stream_out[%0d]", k - 1), 293'(out_data), 293'(dexp[k-1]));
      if (k < n) begin
        in_valid = 1'b1;
        in_mode  = mode;
        in_data  = din[k];
        in_ca    = wca[k];
        in_cb    = wcb[k];
      end else begin
        in_valid = 1'b0;
      end
    end
  endtask

  initial begin
    // From a zero state ks stays 0 for the first word, so top byte = ~d.
    vecs[0] = '{2'b00, 1'b0, 1'b0, 8'h00, 8'h00, 8'hFF};
    vecs[1] = '{2'b01, 1'b0, 1'b0, 8'hA5, 8'hA5, 8'h5A};
    vecs[2] = '{2'b10, 1'b1, 1'b1, 8'h3C, 8'h3C, 8'hC3};
    vecs[3] = '{2'b11, 1'b0, 1'b0, 8'hF0, 8'h00, 8'h0F};
    vecs[4] = '{2'b00, 1'b1, 1'b0, 8'h81, 8'h00, 8'h7E};
    vecs[5] = '{2'b01, 1'b0, 1'b1, 8'hFF, 8'hFF, 8'h00};
    vecs[6] = '{2'b10, 1'b0, 1'b0, 8'h00, 8'h00, 8'hFF};
    vecs[7] = '{2'b01, 1'b1, 1'b1, 8'h12, 8'h12, 8'hED};

    // Reset state
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_state", state_out, '0);
    chk("rst_out_valid", 293'(out_valid), 293'(0));
    chk("rst_out_data", 293'(out_data), 293'(0));
    chk("rst_step_cnt", 293'(step_cnt), 293'(0));
    chk("rst_in_ready", 293'(in_ready), 293'(1));

    // Directed single words from a cleared state
    out_ready = 1'b1;
    for (int v = 0; v < 8; v++) begin
      do_clr();
      in_valid = 1'b1;
      in_mode  = vecs[v].mode;
      in_ca    = vecs[v].ca;
      in_cb    = vecs[v].cb;
      in_data  = vecs[v].d;
      @(negedge clk);
      in_valid = 1'b0;
      chk($sformatf("vec%0d_out_valid", v), 293'(out_valid), 293'(1));
      chk($sformatf("vec%0d_out_data", v), 293'(out_data), 293'(vecs[v].exp_out));
      chk($sformatf("vec%0d_top", v), 293'(state_out[292:285]), 293'(vecs[v].exp_top));
      chk($sformatf("vec%0d_low", v), 293'(state_out[284:0]), 293'(0));
      chk($sformatf("vec%0d_cnt", v), 293'(step_cnt), 293'(8));
    end

    // Round trip: encrypt random words, clear, decrypt the ciphertext
    ms = '0;
    for (int k = 0; k < NWORDS; k++) begin
      din[k] = 8'($urandom);
      wca[k] = 1'($urandom_range(0, 1));
      wcb[k] = 1'($urandom_range(0, 1));
      ms = word_step(ms, din[k], wca[k], wcb[k], 2'b01, mo);
      dexp[k] = mo;
    end
    ms_enc = ms;
    do_clr();
    stream_words(2'b01, NWORDS);
    chk("enc_state", state_out, ms_enc);
    chk("enc_cnt", 293'(step_cnt), 293'(NWORDS * 8));
    for (int k = 0; k < NWORDS; k++) begin
      logic [7:0] t;
      t       = din[k];
      din[k]  = dexp[k];
      dexp[k] = t;
    end
    do_clr();
    stream_words(2'b10, NWORDS);
    chk("dec_state", state_out, ms_enc);

    // Backpressure: one transfer, then stall with output held
    do_clr();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_mode   = 2'b01;
    in_ca     = 1'b0;
    in_cb     = 1'b0;
    in_data   = 8'h3C;
    ms = word_step('0, 8'h3C, 1'b0, 1'b0, 2'b01, mo);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      in_data = 8'h77;
      chk($sformatf("bp_hold_data%0d", c), 293'(out_data), 293'(mo));
      chk($sformatf("bp_in_ready%0d", c), 293'(in_ready), 293'(0));
    end
    chk("bp_cnt", 293'(step_cnt), 293'(8));
    chk("bp_out_valid", 293'(out_valid), 293'(1));
    chk("bp_state", state_out, ms);
    // Release: back-to-back words, no bubbles
    out_ready = 1'b1;
    din[0] = 8'h77; din[1] = 8'h11; din[2] = 8'hE4; din[3] = 8'h09;
    for (int k = 0; k < 4; k++) begin
      in_data = din[k];
      in_ca   = k[0];
      in_cb   = k[1];
      ms = word_step(ms, din[k], k[0], k[1], 2'b01, mo);
      @(negedge clk);
      chk($sformatf("b2b_valid%0d", k), 293'(out_valid), 293'(1));
      chk($sformatf("b2b_data%0d", k), 293'(out_data), 293'(mo));
      chk($sformatf("b2b_cnt%0d", k), 293'(step_cnt), 293'(16 + 8 * k));
    end
    chk("b2b_state", state_out, ms);
    in_valid = 1'b0;
    @(negedge clk);
    chk("drain_valid", 293'(out_valid), 293'(0));
    chk("drain_data_hold", 293'(out_data), 293'(mo));

    // Clear alongside a transfer: word dropped
    in_valid = 1'b1;
    in_data  = 8'h5A;
    clr      = 1'b1;
    chk("clr_in_ready", 293'(in_ready), 293'(1));
    @(negedge clk);
    clr      = 1'b0;
    in_valid = 1'b0;
    chk("clr_state", state_out, '0);
    chk("clr_cnt", 293'(step_cnt), 293'(0));
    chk("clr_out_valid", 293'(out_valid), 293'(0));

    // Asynchronous reset mid-stream
    in_valid = 1'b1;
    in_mode  = 2'b01;
    in_data  = 8'hA5;
    @(negedge clk);
    chk("pre_rst_valid", 293'(out_valid), 293'(1));
    chk("pre_rst_data", 293'(out_data), 293'(8'hA5));
    #2 rst_n = 1'b0;
    #1;
    chk("arst_state", state_out, '0);
    chk("arst_valid", 293'(out_valid), 293'(0));
    chk("arst_data", 293'(out_data), 293'(0));
    chk("arst_cnt", 293'(step_cnt), 293'(0));
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("arst_release_ready", 293'(in_ready), 293'(1));

    // Step counter wrap
    do_clr();
    in_valid = 1'b1;
    in_mode  = 2'b00;
    in_data  = 8'h00;
    repeat (8191) @(negedge clk);
    chk("wrap_pre", 293'(step_cnt), 293'(16'hFFF8));
    @(negedge clk);
    in_valid = 1'b0;
    chk("wrap_zero", 293'(step_cnt), 293'(0));

`ifdef ACORN_STATE_LOAD_EN
    // Direct load: only s154 set, absorb one zero word
    do_clr();
    state_in      = '0;
    state_in[154] = 1'b1;
    state_ld      = 1'b1;
    in_valid      = 1'b1;
    #1;
    chk("ld_in_ready", 293'(in_ready), 293'(0));
    @(negedge clk);
    state_ld = 1'b0;
    chk("ld_state", state_out, state_in);
    chk("ld_cnt", 293'(step_cnt), 293'(0));
    chk("ld_out_valid", 293'(out_valid), 293'(0));
    in_mode = 2'b00;
    in_data = 8'h00;
    in_ca   = 1'b0;
    in_cb   = 1'b0;
    ms = word_step(state_in, 8'h00, 1'b0, 1'b0, 2'b00, mo);
    @(negedge clk);
    in_valid = 1'b0;
    chk("ld_first_ks", 293'(out_data[0]), 293'(1));
    chk("ld_out", 293'(out_data), 293'(mo));
    chk("ld_next_state", state_out, ms);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
